wb_regfile: RTL

- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (ALU result, load data, or link address) and commits it to a 32x32 register file.
- Serves two combinational read ports to the ID stage, with same-cycle write-through bypass.
- Exports the writeback value for EX-stage forwarding and maintains a committed-write counter.

---
 rtl/wb_regfile.sv | 87 ++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to a 32x32 register file,
// serves two write-through read ports and counts commits. Optional macro: WB_REGFILE_SP_INIT_EN.
module wb_regfile #(
    parameter logic [31:0] LINK_OFFSET = 32'd4,
    parameter logic [31:0] SP_INIT     = 32'h000007FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WBRegWrite,
    input  logic [4:0]  WBrd,
    input  logic [1:0]  WBMemtoReg,
    input  logic [31:0] WBPC,
    input  logic [31:0] WBRead_data,
    input  logic [31:0] WBALUOut,
    input  logic [4:0]  IDrs,
    input  logic [4:0]  IDrt,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] WBWrite_data,
    output logic [31:0] commit_count
);

`ifdef WB_REGFILE_SP_INIT_EN
    localparam logic SP_EN = 1'b1;
`else
    localparam logic SP_EN = 1'b0;
`endif
    localparam logic [31:0] R29_RESET = SP_EN ? SP_INIT : 32'd0;

    logic [31:0] r_regs [32];
    logic [31:0] r_commitCount;
    logic [31:0] w_writeData;
    logic        w_commit;

    // Reserved select 2'b11 falls back to the ALU result.
    always_comb begin
        w_writeData = WBALUOut;
        case (WBMemtoReg)
            2'b01:   w_writeData = WBRead_data;
            2'b10:   w_writeData = WBPC + LINK_OFFSET;
            default: w_writeData = WBALUOut;
        endcase
    end

    assign w_commit = WBRegWrite && (WBrd != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= (i == 29) ? R29_RESET : 32'd0;
            end
        end else if (w_commit) begin
            r_regs[WBrd] <= w_writeData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_commitCount <= 32'd0;
        end else if (w_commit) begin
            r_commitCount <= r_commitCount + 32'd1;
        end
    end

    // The bypass lets ID see a value in the same cycle it is being committed.
    always_comb begin
        rs_data = r_regs[IDrs];
        if (IDrs == 5'd0) begin
            rs_data = 32'd0;
        end else if (WBRegWrite && (WBrd == IDrs)) begin
            rs_data = w_writeData;
        end
    end

    always_comb begin
        rt_data = r_regs[IDrt];
        if (IDrt == 5'd0) begin
            rt_data = 32'd0;
        end else if (WBRegWrite && (WBrd == IDrt)) begin
            rt_data = w_writeData;
        end
    end

    assign WBWrite_data = w_writeData;
    assign commit_count = r_commitCount;

endmodule
